// File: rtl/mat_operand_loader.sv
// Matrix operand loader: collects a streamed frame of matrix-1 elements followed
// by matrix-2 elements (row-major), packs them into two wide operand buses and
// holds them for a downstream multiplier until it signals consumption.
// A misplaced start-of-frame marker restarts collection at matrix-1 slot 0.
module mat_operand_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_1      = 8,
  parameter int COL_1      = 4,
  parameter int ROW_2      = 4,
  parameter int COL_2      = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_first,
  output logic [DATA_WIDTH*ROW_1*COL_1-1:0]   mat_1,
  output logic [DATA_WIDTH*ROW_2*COL_2-1:0]   mat_2,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                frame_err
);

  localparam int N1   = ROW_1 * COL_1;
  localparam int N2   = ROW_2 * COL_2;
  localparam int NMAX = (N1 > N2) ? N1 : N2;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [CW-1:0] LAST1 = CW'(N1 - 1);
  localparam logic [CW-1:0] LAST2 = CW'(N2 - 1);

  typedef enum logic [1:0] {
    LOAD_1 = 2'd0,
    LOAD_2 = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e                      state_q;
  logic [CW-1:0]               cnt_q;
  logic                        mValid_q;
  logic                        frameErr_q;
  logic [DATA_WIDTH*N1-1:0]    mat1_q;
  logic [DATA_WIDTH*N2-1:0]    mat2_q;

  logic beat;
  logic misplaced;

  // Upstream is accepted whenever a frame is being collected.
  assign s_ready   = (state_q != HOLD);
  assign beat      = s_valid & s_ready;
  assign misplaced = s_first & ~((state_q == LOAD_1) && (cnt_q == '0));

  assign mat_1     = mat1_q;
  assign mat_2     = mat2_q;
  assign m_valid   = mValid_q;
  assign frame_err = frameErr_q;

  // Frame collection FSM: slot writes, element counter, hand-off and resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_1;
      cnt_q      <= '0;
      mValid_q   <= 1'b0;
      frameErr_q <= 1'b0;
      mat1_q     <= '0;
      mat2_q     <= '0;
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        LOAD_1, LOAD_2: begin
          if (beat) begin
            if (misplaced) begin
              frameErr_q                <= 1'b1;
              mat1_q[0 +: DATA_WIDTH]   <= s_data;
              if (N1 == 1) begin
                cnt_q   <= '0;
                state_q <= LOAD_2;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= LOAD_1;
              end
            end else if (state_q == LOAD_1) begin
              mat1_q[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] <= s_data;
              if (cnt_q == LAST1) begin
                cnt_q   <= '0;
                state_q <= LOAD_2;
              end else begin
                cnt_q   <= cnt_q + CW'(1);
              end
            end else begin
              mat2_q[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] <= s_data;
              if (cnt_q == LAST2) begin
                cnt_q    <= '0;
                state_q  <= HOLD;
                mValid_q <= 1'b1;
              end else begin
                cnt_q    <= cnt_q + CW'(1);
              end
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state_q  <= LOAD_1;
            cnt_q    <= '0;
            mValid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= LOAD_1;
          cnt_q    <= '0;
          mValid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Bench for mat_operand_loader: directed and randomized streams compared against
// a frame-position model that tracks where each element lands in the operands.
module tb_mat_operand_loader;

  localparam int DW = 16;
  localparam int R1 = 8;
  localparam int C1 = 4;
  localparam int R2 = 4;
  localparam int C2 = 8;
  localparam int N1 = R1 * C1;
  localparam int N2 = R2 * C2;

  logic                 clk;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 s_first;
  logic [DW*N1-1:0]     mat_1;
  logic [DW*N2-1:0]     mat_2;
  logic                 m_valid;
  logic                 m_ready;
  logic                 frame_err;

  int total;
  int bad;

  // Reference model state: contents of both matrices, next frame position,
  // whether a complete frame is waiting, and whether an error pulse is due.
  logic [DW-1:0] m1 [N1];
  logic [DW-1:0] m2 [N2];
  int            mPos;
  logic          mHold;
  logic          expErr;

  logic [DW*N1-1:0] ref1;
  logic [DW*N2-1:0] ref2;

  mat_operand_loader #(
    .DATA_WIDTH(DW), .ROW_1(R1), .COL_1(C1), .ROW_2(R2), .COL_2(C2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_first(s_first), .mat_1(mat_1), .mat_2(mat_2),
    .m_valid(m_valid), .m_ready(m_ready), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW*N1-1:0] pack1();
    logic [DW*N1-1:0] r;
    r = '0;
    for (int k = 0; k < N1; k++) r[k*DW +: DW] = m1[k];
    return r;
  endfunction

  function automatic logic [DW*N2-1:0] pack2();
    logic [DW*N2-1:0] r;
    r = '0;
    for (int k = 0; k < N2; k++) r[k*DW +: DW] = m2[k];
    return r;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < N1; k++) m1[k] = '0;
    for (int k = 0; k < N2; k++) m2[k] = '0;
    mPos   = 0;
    mHold  = 1'b0;
    expErr = 1'b0;
  endtask

  task automatic modelBeat(input logic [DW-1:0] d, input logic f);
    if (f && mPos != 0) begin
      expErr = 1'b1;
      m1[0]  = d;
      mPos   = 1;
    end else begin
      if (mPos < N1) m1[mPos] = d;
      else           m2[mPos-N1] = d;
      mPos++;
    end
    if (mPos == N1 + N2) begin
      mHold = 1'b1;
      mPos  = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".s_ready"},   1024'(s_ready),   1024'(!mHold));
    checkOutput({tag, ".m_valid"},   1024'(m_valid),   1024'(mHold));
    checkOutput({tag, ".frame_err"}, 1024'(frame_err), 1024'(expErr));
    checkOutput({tag, ".mat_1"},     1024'(mat_1),     1024'(pack1()));
    checkOutput({tag, ".mat_2"},     1024'(mat_2),     1024'(pack2()));
  endtask

  // One clock of stimulus: drive, advance past the edge, update model, check.
  task automatic applyStimulus(input string tag, input logic v, input logic [DW-1:0] d,
                               input logic f, input logic mr);
    logic beatExp;
    s_valid = v;
    s_data  = d;
    s_first = f;
    m_ready = mr;
    beatExp = v && !mHold;
    @(posedge clk);
    #1;
    expErr = 1'b0;
    if (mHold) begin
      if (mr) begin
        mHold = 1'b0;
        mPos  = 0;
      end
    end else if (beatExp) begin
      modelBeat(d, f);
    end
    checkAll(tag);
  endtask

  task automatic streamFrame(input string tag, input logic mr);
    for (int k = 0; k < N1 + N2; k++)
      applyStimulus(tag, 1'b1, DW'(k + 1), k == 0, mr);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    m_ready = 1'b0;
    modelClear();
    for (int k = 0; k < N1; k++) ref1[k*DW +: DW] = DW'(k + 1);
    for (int k = 0; k < N2; k++) ref2[k*DW +: DW] = DW'(N1 + k + 1);

    // Reset state
    #2;
    checkAll("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset.s_ready_after", 1024'(s_ready), 1024'(1));

    // Back-to-back frame with m_ready held high throughout
    streamFrame("b2b", 1'b1);
    checkOutput("b2b.m_valid",  1024'(m_valid),        1024'(1));
    checkOutput("b2b.m1_lo",    1024'(mat_1[15:0]),    1024'(1));
    checkOutput("b2b.m1_hi",    1024'(mat_1[511:496]), 1024'(32));
    checkOutput("b2b.m2_lo",    1024'(mat_2[15:0]),    1024'(33));
    checkOutput("b2b.m2_hi",    1024'(mat_2[511:496]), 1024'(64));
    checkOutput("b2b.mat_1",    1024'(mat_1),          1024'(ref1));
    checkOutput("b2b.mat_2",    1024'(mat_2),          1024'(ref2));
    applyStimulus("b2b.drain", 1'b0, '0, 1'b0, 1'b1);
    checkOutput("b2b.m_valid_drop", 1024'(m_valid), 1024'(0));

    // Backpressure from downstream while upstream keeps offering data
    streamFrame("bp", 1'b0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus("bp.hold", 1'b1, DW'($urandom), 1'b0, 1'b0);
      checkOutput("bp.s_ready", 1024'(s_ready), 1024'(0));
      checkOutput("bp.m_valid", 1024'(m_valid), 1024'(1));
      checkOutput("bp.mat_1",   1024'(mat_1),   1024'(ref1));
      checkOutput("bp.mat_2",   1024'(mat_2),   1024'(ref2));
    end
    applyStimulus("bp.release", 1'b0, '0, 1'b0, 1'b1);
    checkOutput("bp.s_ready_after", 1024'(s_ready), 1024'(1));

    // Randomly gapped s_valid over a full frame
    for (int c = 0; c < 2000 && !mHold; c++)
      applyStimulus("rnd", 1'($urandom_range(0, 1)), DW'(mPos + 1), mPos == 0, 1'b1);
    checkOutput("rnd.m_valid", 1024'(m_valid), 1024'(1));
    checkOutput("rnd.mat_1",   1024'(mat_1),   1024'(ref1));
    checkOutput("rnd.mat_2",   1024'(mat_2),   1024'(ref2));
    applyStimulus("rnd.release", 1'b0, '0, 1'b0, 1'b1);

    // Misplaced s_first on matrix-2 element 10
    for (int k = 0; k < N1 + 10; k++)
      applyStimulus("err.pre", 1'b1, DW'(k + 1), k == 0, 1'b0);
    applyStimulus("err.hit", 1'b1, DW'(16'h00AA), 1'b1, 1'b0);
    checkOutput("err.pulse", 1024'(frame_err),   1024'(1));
    checkOutput("err.m1_lo", 1024'(mat_1[15:0]), 1024'(16'h00AA));
    for (int k = 0; k < N1 + N2 - 1; k++) begin
      applyStimulus("err.post", 1'b1, DW'($urandom), 1'b0, 1'b0);
      if (k == 0)  checkOutput("err.pulse_end", 1024'(frame_err), 1024'(0));
      if (k == 61) checkOutput("err.m_valid_early", 1024'(m_valid), 1024'(0));
    end
    checkOutput("err.m_valid", 1024'(m_valid), 1024'(1));
    applyStimulus("err.release", 1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of matrix 2
    for (int k = 0; k < N1 + 5; k++)
      applyStimulus("rst.pre", 1'b1, DW'($urandom), k == 0, 1'b1);
    rst_n = 1'b0;
    #2;
    modelClear();
    checkOutput("rst.m_valid", 1024'(m_valid), 1024'(0));
    checkOutput("rst.mat_1",   1024'(mat_1),   1024'(0));
    checkOutput("rst.mat_2",   1024'(mat_2),   1024'(0));
    checkAll("rst.async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    streamFrame("rst.clean", 1'b1);
    checkOutput("rst.clean.mat_1", 1024'(mat_1), 1024'(ref1));
    checkOutput("rst.clean.mat_2", 1024'(mat_2), 1024'(ref2));
    applyStimulus("rst.release", 1'b0, '0, 1'b0, 1'b1);

    // Random data with occasional stray s_first and random handshakes
    for (int c = 0; c < 600; c++)
      applyStimulus("mix", 1'($urandom_range(0, 1)), DW'($urandom),
                    ($urandom_range(0, 39) == 0) || (mPos == 0), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
